// File: rtl/ex_stage_pkg.sv
// Shared constants for the RV32I execute stage: datapath widths and the
// 4-bit ALU control codes {inverse, funct3}.
package ex_stage_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    // Jumps compute their link address outside the ALU; the decoder emits ADD.
    localparam logic [3:0] ALU_JMP  = ALU_ADD;

endpackage

// File: rtl/ex_stage_alu_core.sv
// Combinational ALU and branch comparator. The inverse bit selects SUB/SRA
// for arithmetic codes and negates the comparison for branch codes.
module alu_core
    import ex_stage_pkg::*;
#(
    parameter int XLEN = ex_stage_pkg::XLEN
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      ctrl,
    output logic [XLEN-1:0] result,
    output logic            taken
);

    logic            inv_s;
    logic [2:0]      f3_s;
    logic [4:0]      shamt_s;
    logic            lt_s;
    logic            ltu_s;
    logic            eq_s;

    assign inv_s   = ctrl[3];
    assign f3_s    = ctrl[2:0];
    assign shamt_s = b[4:0];
    assign lt_s    = $signed(a) < $signed(b);
    assign ltu_s   = a < b;
    assign eq_s    = a == b;

    // ALU result selection by funct3
    always_comb begin
        result = {XLEN{1'b0}};
        case (f3_s)
            F3_ADD:  result = inv_s ? (a - b) : (a + b);
            F3_SLL:  result = a << shamt_s;
            F3_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
            F3_SLTU: result = {{(XLEN-1){1'b0}}, ltu_s};
            F3_XOR:  result = a ^ b;
            F3_SRL:  result = inv_s ? $unsigned($signed(a) >>> shamt_s) : (a >> shamt_s);
            F3_OR:   result = a | b;
            F3_AND:  result = a & b;
            default: result = {XLEN{1'b0}};
        endcase
    end

    // Branch condition; only EQ/LT/LTU families can be taken
    always_comb begin
        taken = 1'b0;
        case (f3_s)
            F3_XOR:  taken = eq_s ^ inv_s;
            F3_SLT:  taken = lt_s ^ inv_s;
            F3_SLTU: taken = ltu_s ^ inv_s;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and
// the EX/MEM output register under a valid/ready handshake.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int XLEN      = ex_stage_pkg::XLEN,
    parameter int REG_IDX_W = ex_stage_pkg::REG_IDX_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_alu_ctrl,
    input  logic                 in_is_branch,
    input  logic                 in_is_jump,
    input  logic                 in_use_imm,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [XLEN-1:0]      in_rs1_val,
    input  logic [XLEN-1:0]      in_rs2_val,
    input  logic [REG_IDX_W-1:0] in_rs1_idx,
    input  logic [REG_IDX_W-1:0] in_rs2_idx,
    input  logic [REG_IDX_W-1:0] in_rd_idx,
    input  logic                 in_reg_write,
    input  logic                 in_jalr,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd_idx,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_result,
    output logic [XLEN-1:0]      out_rs2_val,
    output logic [REG_IDX_W-1:0] out_rd_idx,
    output logic                 out_reg_write,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc
);

    logic                 out_valid_r;
    logic [XLEN-1:0]      out_result_r;
    logic [XLEN-1:0]      out_rs2_val_r;
    logic [REG_IDX_W-1:0] out_rd_idx_r;
    logic                 out_reg_write_r;
    logic                 redirect_valid_r;
    logic [XLEN-1:0]      redirect_pc_r;

    logic                 accept_s;
    logic [XLEN-1:0]      op_a_s;
    logic [XLEN-1:0]      rs2_fwd_s;
    logic [XLEN-1:0]      op_b_s;
    logic [XLEN-1:0]      alu_result_s;
    logic                 br_taken_s;
    logic [XLEN-1:0]      pc_plus4_s;
    logic [XLEN-1:0]      pc_target_s;
    logic [XLEN-1:0]      jalr_sum_s;
    logic [XLEN-1:0]      result_s;
    logic                 redirect_s;
    logic [XLEN-1:0]      target_s;
    logic                 fwd1_ex_s;
    logic                 fwd1_wb_s;
    logic                 fwd2_ex_s;
    logic                 fwd2_wb_s;

    assign in_ready = !out_valid_r || out_ready;
    assign accept_s = in_valid && in_ready;

    // The output register is the youngest producer, so it beats writeback.
    assign fwd1_ex_s = (in_rs1_idx != {REG_IDX_W{1'b0}}) && out_valid_r && out_reg_write_r
                       && (out_rd_idx_r == in_rs1_idx);
    assign fwd1_wb_s = (in_rs1_idx != {REG_IDX_W{1'b0}}) && wb_valid && (wb_rd_idx == in_rs1_idx);
    assign fwd2_ex_s = (in_rs2_idx != {REG_IDX_W{1'b0}}) && out_valid_r && out_reg_write_r
                       && (out_rd_idx_r == in_rs2_idx);
    assign fwd2_wb_s = (in_rs2_idx != {REG_IDX_W{1'b0}}) && wb_valid && (wb_rd_idx == in_rs2_idx);

    // Operand forwarding muxes
    always_comb begin
        op_a_s    = in_rs1_val;
        rs2_fwd_s = in_rs2_val;
        if (fwd1_ex_s) begin
            op_a_s = out_result_r;
        end else if (fwd1_wb_s) begin
            op_a_s = wb_data;
        end else begin
            op_a_s = in_rs1_val;
        end
        if (fwd2_ex_s) begin
            rs2_fwd_s = out_result_r;
        end else if (fwd2_wb_s) begin
            rs2_fwd_s = wb_data;
        end else begin
            rs2_fwd_s = in_rs2_val;
        end
    end

    assign op_b_s = in_use_imm ? in_imm : rs2_fwd_s;

    alu_core #(
        .XLEN (XLEN)
    ) u_alu_core (
        .a      (op_a_s),
        .b      (op_b_s),
        .ctrl   (in_alu_ctrl),
        .result (alu_result_s),
        .taken  (br_taken_s)
    );

    assign pc_plus4_s  = in_pc + XLEN'(3'd4);
    assign pc_target_s = in_pc + in_imm;
    assign jalr_sum_s  = op_a_s + in_imm;

    // Result and redirect selection for jumps and branches
    always_comb begin
        result_s   = alu_result_s;
        redirect_s = 1'b0;
        target_s   = pc_target_s;
        if (in_is_jump) begin
            result_s   = pc_plus4_s;
            redirect_s = 1'b1;
            target_s   = in_jalr ? {jalr_sum_s[XLEN-1:1], 1'b0} : pc_target_s;
        end else if (in_is_branch) begin
            result_s   = alu_result_s;
            redirect_s = br_taken_s;
            target_s   = pc_target_s;
        end else begin
            result_s   = alu_result_s;
            redirect_s = 1'b0;
            target_s   = pc_target_s;
        end
    end

    // EX/MEM register; flush beats accept, a stalled output holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r      <= 1'b0;
            out_result_r     <= {XLEN{1'b0}};
            out_rs2_val_r    <= {XLEN{1'b0}};
            out_rd_idx_r     <= {REG_IDX_W{1'b0}};
            out_reg_write_r  <= 1'b0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= {XLEN{1'b0}};
        end else if (flush) begin
            out_valid_r      <= 1'b0;
            redirect_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r      <= 1'b1;
            out_result_r     <= result_s;
            out_rs2_val_r    <= rs2_fwd_s;
            out_rd_idx_r     <= in_rd_idx;
            out_reg_write_r  <= in_reg_write && !in_is_branch;
            redirect_valid_r <= redirect_s;
            if (redirect_s) begin
                redirect_pc_r <= target_s;
            end
        end else begin
            if (out_ready) begin
                out_valid_r <= 1'b0;
            end
            redirect_valid_r <= 1'b0;
        end
    end

    assign out_valid      = out_valid_r;
    assign out_result     = out_result_r;
    assign out_rs2_val    = out_rs2_val_r;
    assign out_rd_idx     = out_rd_idx_r;
    assign out_reg_write  = out_reg_write_r;
    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: an instruction-level reference model is
// compared every cycle, with literal expectations on key vectors.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_alu_ctrl;
    logic        in_is_branch;
    logic        in_is_jump;
    logic        in_use_imm;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic [4:0]  in_rs1_idx;
    logic [4:0]  in_rs2_idx;
    logic [4:0]  in_rd_idx;
    logic        in_reg_write;
    logic        in_jalr;
    logic        wb_valid;
    logic [4:0]  wb_rd_idx;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [31:0] out_rs2_val;
    logic [4:0]  out_rd_idx;
    logic        out_reg_write;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int pass_cnt = 0;
    int total_cnt = 0;

    ex_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_alu_ctrl    (in_alu_ctrl),
        .in_is_branch   (in_is_branch),
        .in_is_jump     (in_is_jump),
        .in_use_imm     (in_use_imm),
        .in_pc          (in_pc),
        .in_imm         (in_imm),
        .in_rs1_val     (in_rs1_val),
        .in_rs2_val     (in_rs2_val),
        .in_rs1_idx     (in_rs1_idx),
        .in_rs2_idx     (in_rs2_idx),
        .in_rd_idx      (in_rd_idx),
        .in_reg_write   (in_reg_write),
        .in_jalr        (in_jalr),
        .wb_valid       (wb_valid),
        .wb_rd_idx      (wb_rd_idx),
        .wb_data        (wb_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_rs2_val    (out_rs2_val),
        .out_rd_idx     (out_rd_idx),
        .out_reg_write  (out_reg_write),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic        m_valid, m_redir, m_rw;
    logic [31:0] m_result, m_rs2, m_rpc;
    logic [4:0]  m_rd;

    function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b1000: return a - b;
            4'b0001, 4'b1001: return a << b[4:0];
            4'b0010, 4'b1010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011, 4'b1011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100, 4'b1100: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b1101: return $unsigned($signed(a) >>> b[4:0]);
            4'b0110, 4'b1110: return a | b;
            4'b0111, 4'b1111: return a & b;
            default: return a + b;
        endcase
    endfunction

    function automatic logic taken_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0100: return a == b;
            4'b1100: return a != b;
            4'b0010: return $signed(a) < $signed(b);
            4'b1010: return $signed(a) >= $signed(b);
            4'b0011: return a < b;
            4'b1011: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] src(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0) return rf;
        if (m_valid && m_rw && m_rd == idx) return m_result;
        if (wb_valid && wb_rd_idx == idx) return wb_data;
        return rf;
    endfunction

    function automatic logic [31:0] opa();
        return src(in_rs1_idx, in_rs1_val);
    endfunction

    function automatic logic [31:0] opb();
        return in_use_imm ? in_imm : src(in_rs2_idx, in_rs2_val);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0; m_redir <= 1'b0; m_rw <= 1'b0;
            m_result <= 32'd0; m_rs2 <= 32'd0; m_rpc <= 32'd0; m_rd <= 5'd0;
        end else if (flush) begin
            m_valid <= 1'b0;
            m_redir <= 1'b0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid  <= 1'b1;
            m_result <= in_is_jump ? in_pc + 32'd4 : alu_ref(in_alu_ctrl, opa(), opb());
            m_rs2    <= src(in_rs2_idx, in_rs2_val);
            m_rd     <= in_rd_idx;
            m_rw     <= in_reg_write && !in_is_branch;
            m_redir  <= in_is_jump || (in_is_branch && taken_ref(in_alu_ctrl, opa(), opb()));
            m_rpc    <= (in_is_jump && in_jalr) ? ((opa() + in_imm) & 32'hFFFF_FFFE) : in_pc + in_imm;
        end else begin
            if (out_ready) m_valid <= 1'b0;
            m_redir <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, !m_valid || out_ready});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_redir});
            if (m_valid) begin
                chk("out_result", out_result, m_result);
                chk("out_rs2_val", out_rs2_val, m_rs2);
                chk("out_rd_idx", {27'd0, out_rd_idx}, {27'd0, m_rd});
                chk("out_reg_write", {31'd0, out_reg_write}, {31'd0, m_rw});
            end
            if (m_redir) chk("redirect_pc", redirect_pc, m_rpc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_op(input logic [3:0] c, input logic br, input logic jmp, input logic jalr,
                          input logic ui, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] v1, input logic [31:0] v2, input logic [4:0] i1,
                          input logic [4:0] i2, input logic [4:0] rd, input logic rw);
        in_alu_ctrl = c; in_is_branch = br; in_is_jump = jmp; in_jalr = jalr;
        in_use_imm = ui; in_pc = pc; in_imm = imm; in_rs1_val = v1; in_rs2_val = v2;
        in_rs1_idx = i1; in_rs2_idx = i2; in_rd_idx = rd; in_reg_write = rw;
    endtask

    task automatic send();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    logic [3:0]  v_ctrl [6] = '{4'b1000, 4'b0010, 4'b0011, 4'b1110, 4'b0001, 4'b0101};
    logic [31:0] v_a    [6] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00F0, 32'h0000_0003, 32'h8000_0000};
    logic [31:0] v_b    [6] = '{32'd7, 32'd1, 32'd1, 32'h0000_000F, 32'h0000_0024, 32'h0000_001F};
    logic [31:0] v_exp  [6] = '{32'hFFFF_FFFE, 32'd1, 32'd0, 32'h0000_00FF, 32'h0000_0030, 32'd1};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        wb_valid = 1'b0; wb_rd_idx = 5'd0; wb_data = 32'd0;
        set_op(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_result", out_result, 32'd0);
        chk("reset_redirect_pc", redirect_pc, 32'd0);
        rst_n = 1'b1;
        idle_cycle();

        // ALU ops with register operands
        for (int i = 0; i < 6; i++) begin
            set_op(v_ctrl[i], 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'd0, v_a[i], v_b[i], 5'd10, 5'd11, 5'd3, 1'b1);
            send();
            chk("alu_vec", out_result, v_exp[i]);
        end
        set_op(4'b1101, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'd4, 32'h8000_0000, 32'd0, 5'd10, 5'd0, 5'd3, 1'b1);
        send();
        chk("sra_imm", out_result, 32'hF800_0000);

        // Branches
        set_op(4'b1100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h20, 32'd3, 32'd3, 5'd11, 5'd12, 5'd0, 1'b0);
        send();
        chk("bne_equal_no_redirect", {31'd0, redirect_valid}, 32'd0);
        set_op(4'b1100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h20, 32'd3, 32'd4, 5'd11, 5'd12, 5'd0, 1'b0);
        send();
        chk("bne_taken_redirect", {31'd0, redirect_valid}, 32'd1);
        chk("bne_taken_pc", redirect_pc, 32'h120);
        chk("bne_reg_write", {31'd0, out_reg_write}, 32'd0);
        idle_cycle();
        chk("bne_redirect_pulse_end", {31'd0, redirect_valid}, 32'd0);
        set_op(4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h8, 32'hFFFF_FFFF, 32'd1, 5'd11, 5'd12, 5'd0, 1'b0);
        send();
        chk("bge_neg_not_taken", {31'd0, redirect_valid}, 32'd0);
        set_op(4'b1011, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h8, 32'hFFFF_FFFF, 32'd1, 5'd11, 5'd12, 5'd0, 1'b0);
        send();
        chk("bgeu_taken_pc", redirect_pc, 32'h208);

        // Forwarding: EX register beats writeback
        wb_valid = 1'b1; wb_rd_idx = 5'd1; wb_data = 32'd4;
        idle_cycle();
        set_op(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'd9, 32'd0, 32'd0, 5'd0, 5'd0, 5'd1, 1'b1);
        send();
        set_op(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4, 32'd0, 32'd0, 32'd0, 5'd1, 5'd1, 5'd2, 1'b1);
        send();
        chk("fwd_ex", out_result, 32'd18);
        chk("fwd_ex_store_data", out_rs2_val, 32'd9);
        idle_cycle();
        send();
        chk("fwd_wb", out_result, 32'd8);
        wb_rd_idx = 5'd0;
        set_op(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'd9, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b1);
        send();
        set_op(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd2, 1'b1);
        send();
        chk("fwd_x0_none", out_result, 32'd0);
        wb_valid = 1'b0;

        // Backpressure
        set_op(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h55, 32'd0, 32'd0, 5'd0, 5'd0, 5'd5, 1'b1);
        send();
        out_ready = 1'b0;
        set_op(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h66, 32'd0, 32'd0, 5'd0, 5'd0, 5'd6, 1'b1);
        in_valid = 1'b1;
        #1;
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_result_hold", out_result, 32'h55);
            chk("stall_rd_hold", {27'd0, out_rd_idx}, 32'd5);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("release_accept", out_result, 32'h66);

        // Jumps and flush
        set_op(4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'd0, 32'h1003, 32'd0, 5'd7, 5'd0, 5'd1, 1'b1);
        send();
        chk("jalr_link", out_result, 32'h44);
        chk("jalr_redirect", {31'd0, redirect_valid}, 32'd1);
        chk("jalr_target", redirect_pc, 32'h1002);
        flush = 1'b1;
        send();
        flush = 1'b0;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_redirect", {31'd0, redirect_valid}, 32'd0);
        set_op(4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 32'hFFFF_FFF8, 32'd0, 32'd0, 5'd0, 5'd0, 5'd1, 1'b1);
        send();
        chk("jal_link", out_result, 32'h204);
        chk("jal_target", redirect_pc, 32'h1F8);

        // Reset mid-stream with a valid jump in flight
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("midreset_result", out_result, 32'd0);
        chk("midreset_rs2", out_rs2_val, 32'd0);
        chk("midreset_rd", {27'd0, out_rd_idx}, 32'd0);
        chk("midreset_rw", {31'd0, out_reg_write}, 32'd0);
        chk("midreset_rpc", redirect_pc, 32'd0);
        #3;
        rst_n = 1'b1;
        repeat (2) idle_cycle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
